// File: rtl/hack_fetch_pkg.sv
// -----------------------------------------------------------------------------
// hack_fetch_pkg
// Shared definitions for the Hack instruction-fetch stage, the CPU decode
// stage and the program ROM.
//   ADDR_W_DEF / DATA_W_DEF : default program-counter and instruction widths
//   RESET_VEC_DEF           : default first address fetched after reset
//   ROM_ADDR_W              : width of the ROM address port (fetch addresses
//                             are zero-extended to this width)
//   addr_t / instr_t        : default-width address and instruction types
//   rom_image()             : built-in program image served by onchip_rom
// -----------------------------------------------------------------------------
package hack_fetch_pkg;

    localparam int ADDR_W_DEF    = 15;
    localparam int DATA_W_DEF    = 16;
    localparam int RESET_VEC_DEF = 0;
    localparam int ROM_ADDR_W    = 16;

    typedef logic [ADDR_W_DEF-1:0] addr_t;
    typedef logic [DATA_W_DEF-1:0] instr_t;
    typedef logic [ROM_ADDR_W-1:0] rom_addr_t;

    // Built-in image: word i holds i + 0x100, so every address reads back a
    // distinct, recognisable word (bring-up and fetch-order tracing).
    localparam instr_t IMAGE_BASE = 16'h0100;

    function automatic instr_t rom_image(input rom_addr_t a);
        return instr_t'(a) + IMAGE_BASE;
    endfunction

endpackage

// File: rtl/onchip_rom.sv
// -----------------------------------------------------------------------------
// onchip_rom
// Synchronous program ROM with a 1-cycle read latency: the address presented
// in cycle N appears on o_q in cycle N+1.
// Parameters:
//   DATA_W : word width
//   PRG    : name of the program image for the memory-generator flow
// Ports:
//   i_clk  : clock, read register updates on the rising edge
//   i_addr : read address (ROM_ADDR_W bits)
//   o_q    : registered read data
// -----------------------------------------------------------------------------
module onchip_rom
    import hack_fetch_pkg::*;
#(
    parameter int    DATA_W = DATA_W_DEF,
    parameter string PRG    = ""
)(
    input  logic              i_clk,
    input  rom_addr_t         i_addr,
    output logic [DATA_W-1:0] o_q
);

    logic [DATA_W-1:0] r_q;
    logic              w_unused_prg;

    // The image name is consumed by the memory generator, not by this model.
    assign w_unused_prg = (PRG != "");

    // NOTE: the read register has no reset; its value is qualified downstream
    // by instr_valid, so a reset would only cost routing.
    always_ff @(posedge i_clk) begin
        r_q <= DATA_W'(rom_image(i_addr));
    end

    assign o_q = r_q;

endmodule

// File: rtl/hack_fetch_unit.sv
// -----------------------------------------------------------------------------
// hack_fetch_unit
// Instruction-fetch stage for the Hack CPU. Owns the program counter and
// drives a synchronous on-chip ROM. Taken jumps cost no bubble; stalls of any
// length hold the output instruction bit-identical by re-reading the address
// of the current instruction.
// Parameters:
//   ADDR_W    : program-counter width (must not exceed ROM_ADDR_W)
//   DATA_W    : instruction width
//   RESET_VEC : first address fetched after reset
//   PRG       : ROM image name, passed to onchip_rom
// Ports:
//   a_clk       : clock, rising edge
//   a_rst       : synchronous active-high reset
//   jmp         : taken jump this cycle (wins over stall)
//   jmp_addr    : jump target
//   stall       : hold the current instruction (level-sensitive, any length)
//   instr       : instruction for decode
//   instr_valid : instr is meaningful
//   instr_pc    : address of instr (only when FETCH_PC_OUT_EN is defined)
// Configuration macro: FETCH_PC_OUT_EN
// -----------------------------------------------------------------------------
module hack_fetch_unit
    import hack_fetch_pkg::*;
#(
    parameter int                ADDR_W    = ADDR_W_DEF,
    parameter int                DATA_W    = DATA_W_DEF,
    parameter logic [ADDR_W-1:0] RESET_VEC = ADDR_W'(RESET_VEC_DEF),
    parameter string             PRG       = ""
)(
    input  logic              a_clk,
    input  logic              a_rst,
    input  logic              jmp,
    input  logic [ADDR_W-1:0] jmp_addr,
    input  logic              stall,
    output logic [DATA_W-1:0] instr,
`ifdef FETCH_PC_OUT_EN
    output logic [ADDR_W-1:0] instr_pc,
`endif
    output logic              instr_valid
);

    logic [ADDR_W-1:0] r_pc;       // next sequential address
    logic [ADDR_W-1:0] r_addr_q;   // address of the instruction now on instr
    logic              r_valid_q;
    logic [ADDR_W-1:0] w_rom_addr;
    rom_addr_t         w_rom_addr_ext;

    // Address selection: reset > jmp > stall > sequential. Replaying r_addr_q
    // during a stall makes the ROM return the same word every stalled cycle.
    always_comb begin
        // NOTE: default assigned first so every path drives it (no latch).
        w_rom_addr = r_pc;
        if (a_rst) begin
            w_rom_addr = RESET_VEC;
        end else if (jmp) begin
            w_rom_addr = jmp_addr;
        end else if (stall) begin
            w_rom_addr = r_addr_q;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge a_clk) begin
        if (a_rst) begin
            r_pc      <= RESET_VEC;
            r_addr_q  <= RESET_VEC;
            r_valid_q <= 1'b0;
        end else begin
            r_addr_q  <= w_rom_addr;
            r_valid_q <= 1'b1;
            // A jump overrides a stall, so the pc advances past the target.
            // The increment wraps modulo 2^ADDR_W.
            if (jmp || !stall) begin
                r_pc <= w_rom_addr + ADDR_W'(1);
            end
        end
    end

    assign w_rom_addr_ext = ROM_ADDR_W'(w_rom_addr);

    onchip_rom #(
        .DATA_W (DATA_W),
        .PRG    (PRG)
    ) u_rom (
        .i_clk  (a_clk),
        .i_addr (w_rom_addr_ext),
        .o_q    (instr)
    );

    assign instr_valid = r_valid_q;

`ifdef FETCH_PC_OUT_EN
    assign instr_pc = r_addr_q;
`else
    // r_addr_q stays internal: it is still needed for stall replay.
`endif

endmodule

// File: tb/tb_hack_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_hack_fetch_unit
// Self-checking bench for hack_fetch_unit. One instance at the default
// 15-bit width and one at ADDR_W=4 for the wrap-around case. Each driven
// cycle pushes the expected next output (valid flag and fetch address) into
// a scoreboard queue; the entry is popped and compared on the falling edge
// after the clock. The ROM image is word i = i + 0x100.
// Honours FETCH_PC_OUT_EN by also checking instr_pc.
// -----------------------------------------------------------------------------
module tb_hack_fetch_unit;

    typedef struct {
        bit          valid;
        logic [14:0] addr;
    } exp_t;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // 15-bit instance
    logic        rst, jmp, stall;
    logic [14:0] jaddr;
    logic [15:0] instr;
    logic        instr_valid;
    // 4-bit instance
    logic        rst4, jmp4, stall4;
    logic [3:0]  jaddr4;
    logic [15:0] instr4;
    logic        instr_valid4;
`ifdef FETCH_PC_OUT_EN
    logic [14:0] instr_pc;
    logic [3:0]  instr_pc4;
`endif

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t sb[$];
    exp_t sb4[$];

    hack_fetch_unit dut (
        .a_clk       (clk),
        .a_rst       (rst),
        .jmp         (jmp),
        .jmp_addr    (jaddr),
        .stall       (stall),
        .instr       (instr),
`ifdef FETCH_PC_OUT_EN
        .instr_pc    (instr_pc),
`endif
        .instr_valid (instr_valid)
    );

    hack_fetch_unit #(.ADDR_W(4)) dut4 (
        .a_clk       (clk),
        .a_rst       (rst4),
        .jmp         (jmp4),
        .jmp_addr    (jaddr4),
        .stall       (stall4),
        .instr       (instr4),
`ifdef FETCH_PC_OUT_EN
        .instr_pc    (instr_pc4),
`endif
        .instr_valid (instr_valid4)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] rom_word(input logic [14:0] a);
        return {1'b0, a} + 16'h0100;
    endfunction

    // One clock of the 15-bit instance: drive, record expectation, compare.
    task automatic cyc(input string tag, input bit r, input bit j, input logic [14:0] ja,
                       input bit s, input bit ev, input logic [14:0] ea);
        exp_t e;
        exp_t got;
        rst   = r;
        jmp   = j;
        jaddr = ja;
        stall = s;
        e.valid = ev;
        e.addr  = ea;
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
        got = sb.pop_front();
        check({tag, ".valid"}, 32'(instr_valid), 32'(got.valid));
        if (got.valid) begin
            check({tag, ".instr"}, 32'(instr), 32'(rom_word(got.addr)));
        end
`ifdef FETCH_PC_OUT_EN
        check({tag, ".pc"}, 32'(instr_pc), 32'(got.addr));
`endif
    endtask

    // One clock of the 4-bit instance.
    task automatic cyc4(input string tag, input bit r, input bit j, input logic [3:0] ja,
                        input bit s, input bit ev, input logic [3:0] ea);
        exp_t e;
        exp_t got;
        rst4   = r;
        jmp4   = j;
        jaddr4 = ja;
        stall4 = s;
        e.valid = ev;
        e.addr  = {11'b0, ea};
        sb4.push_back(e);
        @(posedge clk);
        @(negedge clk);
        got = sb4.pop_front();
        check({tag, ".valid"}, 32'(instr_valid4), 32'(got.valid));
        if (got.valid) begin
            check({tag, ".instr"}, 32'(instr4), 32'(rom_word(got.addr)));
        end
`ifdef FETCH_PC_OUT_EN
        check({tag, ".pc"}, 32'(instr_pc4), 32'(got.addr));
`endif
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        rst  = 1'b1; jmp  = 1'b0; stall  = 1'b0; jaddr  = '0;
        rst4 = 1'b1; jmp4 = 1'b0; stall4 = 1'b0; jaddr4 = '0;
        @(negedge clk);

        // Reset state
        repeat (3) cyc("reset", 1, 0, 15'h0, 0, 0, 15'h0);

        // Free run from RESET_VEC
        for (int i = 0; i < 8; i++) cyc("run", 0, 0, 15'h0, 0, 1, 15'(i));

        // Stall 5 cycles on ROM[7]: ROM[7] seen 6 times, then ROM[8]
        repeat (5) cyc("stall", 0, 0, 15'h0, 1, 1, 15'd7);
        cyc("resume", 0, 0, 15'h0, 0, 1, 15'd8);
        cyc("resume", 0, 0, 15'h0, 0, 1, 15'd9);

        // Jump, no bubble
        cyc("jmp", 0, 1, 15'h0040, 0, 1, 15'h0040);
        cyc("jmp_seq", 0, 0, 15'h0, 0, 1, 15'h0041);
        cyc("jmp_seq", 0, 0, 15'h0, 0, 1, 15'h0042);

        // Jump together with stall: jump wins, stall dropped
        cyc("jmp_stall", 0, 1, 15'h0010, 1, 1, 15'h0010);
        cyc("jmp_stall_seq", 0, 0, 15'h0, 0, 1, 15'h0011);

        // Jump to all-ones, then wrap to 0
        cyc("jmp_max", 0, 1, 15'h7fff, 0, 1, 15'h7fff);
        cyc("wrap", 0, 0, 15'h0, 0, 1, 15'h0000);
        cyc("wrap", 0, 0, 15'h0, 0, 1, 15'h0001);

        // Reset mid-stall with pc = 0x20 (instr = ROM[0x1F])
        cyc("pre", 0, 1, 15'h001e, 0, 1, 15'h001e);
        cyc("pre", 0, 0, 15'h0, 0, 1, 15'h001f);
        repeat (2) cyc("pre_stall", 0, 0, 15'h0, 1, 1, 15'h001f);
        cyc("rst_stall", 1, 0, 15'h0, 1, 0, 15'h0);
        cyc("restart", 0, 0, 15'h0, 0, 1, 15'h0000);
        cyc("restart", 0, 0, 15'h0, 0, 1, 15'h0001);

        // Reset coincident with jump: jump ignored
        cyc("rst_jmp", 1, 1, 15'h0055, 0, 0, 15'h0);
        cyc("rst_jmp_restart", 0, 0, 15'h0, 0, 1, 15'h0000);

        // ADDR_W = 4: sequential wrap, then jump to 0xF and wrap
        repeat (2) cyc4("r4_reset", 1, 0, 4'h0, 0, 0, 4'h0);
        for (int i = 0; i < 16; i++) cyc4("r4_run", 0, 0, 4'h0, 0, 1, 4'(i));
        cyc4("r4_wrap", 0, 0, 4'h0, 0, 1, 4'h0);
        cyc4("r4_wrap", 0, 0, 4'h0, 0, 1, 4'h1);
        cyc4("r4_jmp", 0, 1, 4'hf, 0, 1, 4'hf);
        cyc4("r4_jmp_wrap", 0, 0, 4'h0, 0, 1, 4'h0);
        cyc4("r4_jmp_wrap", 0, 0, 4'h0, 0, 1, 4'h1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/hack_fetch_unit.md
# hack_fetch_unit

Parametrised instruction-fetch stage for the Hack CPU. It owns the program counter and drives a synchronous on-chip ROM (`onchip_rom`, 1-cycle read latency). It supports taken jumps with zero bubble and stalls of arbitrary length: the instruction on the output is held stable for the whole stall. It sits between the program ROM and the CPU decode stage, replacing the fixed 15/16-bit, single-cycle-stall fetch logic.

## Interface
- `ADDR_W`, 15: program-counter and ROM address width.
- `DATA_W`, 16: instruction width.
- `RESET_VEC`, 0: first address fetched after reset.
- `PRG`, "": ROM init file, passed through to `onchip_rom`.
- `a_clk` in 1: the single clock; all state updates on its rising edge.
- `a_rst` in 1: synchronous, active-high reset.
- `jmp` in 1: taken jump this cycle.
- `jmp_addr` in `ADDR_W`: jump target, sampled when `jmp`=1.
- `stall` in 1: hold the current instruction; any length, level-sensitive.
- `instr` out `DATA_W`: instruction for decode (ROM `q`).
- `instr_valid` out 1: `instr` is meaningful.
- `instr_pc` out `ADDR_W`: address of `instr`. Present only with `FETCH_PC_OUT_EN`.

## Operation
- State registers:
  - `pc`: next sequential address.
  - `addr_q`: address presented to the ROM in the previous cycle, i.e. the address of the current `instr`.
  - `valid_q`.
- ROM address (combinational), priority `jmp` > `stall` > sequential:
  - `rom_addr` = `jmp` ? `jmp_addr` : (`stall` ? `addr_q` : `pc`).
- Update each cycle when `a_rst`=0:
  - `addr_q` <= `rom_addr`.
  - `valid_q` <= 1.
  - `pc` <= `rom_addr` + 1 when `jmp`=1 or `stall`=0; otherwise `pc` holds.
- During a stall, re-reading `addr_q` keeps `instr` bit-identical for every stalled cycle, with no stall-length limit.
- `jmp` and `stall` asserted together: the jump wins. Its target is fetched and the stall is dropped for that cycle.
- Arithmetic is modulo 2^`ADDR_W`: `pc` at all-ones wraps to 0, and `jmp_addr` all-ones gives `pc` = 0.
- `instr_valid` = `valid_q`; `instr_pc` = `addr_q`.
- Reset (any cycle, including mid-stall or coincident with `jmp`) is top priority:
  - `pc` <= `RESET_VEC`, `addr_q` <= `RESET_VEC`, `valid_q` <= 0.
  - `jmp` and `stall` are ignored.

## Timing
- Reset values:
  - `instr_valid` = 0.
  - `instr_pc` = `RESET_VEC`.
  - `instr` is undefined (ROM output) while `instr_valid` = 0.
- While `a_rst` is held, the ROM is addressed with `RESET_VEC`.
- First cycle after reset deasserts: `rom_addr` = `RESET_VEC`. The following cycle has `instr` = ROM[`RESET_VEC`] and `instr_valid` = 1.
- Fetch latency is 1 cycle: the address presented in cycle N gives `instr` in cycle N+1.
- Jump: `jmp` in cycle N gives `instr` = ROM[`jmp_addr`] in cycle N+1, then ROM[`jmp_addr`+1] in N+2. No bubble.
- Stall: `stall` high during cycles N..N+k holds `instr` at its cycle-N value through cycle N+k+1. Sequential fetch resumes from the saved `pc`.
- Throughput: 1 instruction/cycle when not stalled.

## Configuration
- `FETCH_PC_OUT_EN` defined: the `instr_pc` port exists and equals `addr_q`, giving the CPU return addresses and the debug trace.
- Macro undefined: the port is absent. `addr_q` is still kept internally for stall replay, and behaviour is otherwise identical.

## Structure
- Package `hack_fetch_pkg`:
  - `ADDR_W`/`DATA_W` defaults.
  - `RESET_VEC` default.
  - Address/instruction typedefs shared with the CPU and the ROM.
- Sub-module: `onchip_rom`, instantiated once, with address zero-extended to its port width. No other hierarchy.

## Test plan
- Reset then free-run, ROM[i]=i+0x100 → after the valid edge, `instr` = 0x100, 0x101, 0x102… one per cycle; `instr_valid` = 0 only in the first post-reset cycle.
- `jmp`=1, `jmp_addr`=0x0040 in cycle N → `instr` = ROM[0x40] at N+1, ROM[0x41] at N+2; no repeated or skipped word.
- `stall` held 5 cycles while `instr` = ROM[7] → `instr` = ROM[7] for 6 cycles, then ROM[8]. `instr_pc` = 7 throughout when enabled.
- `stall` and `jmp` both high, target 0x10 → ROM[0x10] next cycle, and the stall is ignored.
- `ADDR_W`=4: `pc` at 0xF, plus a jump to 0xF → fetch order 0xF, 0x0, 0x1.
- `a_rst` asserted mid-stall at `pc`=0x20 → `instr_valid` = 0 next cycle, then restart at `RESET_VEC`.
